// File: rtl/dir_arb_pkg.sv
// Shared constants for the direction arbiter: direction codes, scancodes, decoder states.
// The WASD lookup is only used when DIR_ARB_WASD_EN is defined.
package dir_arb_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kb_state_e;

    function automatic logic [2:0] arrow_dir(input logic [7:0] sc);
        logic [2:0] d;
        d = DIR_NONE;
        case (sc)
            SC_UP:    d = DIR_UP;
            SC_RIGHT: d = DIR_RIGHT;
            SC_DOWN:  d = DIR_DOWN;
            SC_LEFT:  d = DIR_LEFT;
            default:  d = DIR_NONE;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] wasd_dir(input logic [7:0] sc);
        logic [2:0] d;
        d = DIR_NONE;
        case (sc)
            SC_W:    d = DIR_UP;
            SC_D:    d = DIR_RIGHT;
            SC_S:    d = DIR_DOWN;
            SC_A:    d = DIR_LEFT;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One board switch: 2-flop synchronizer, down-counting debounce timer, and a
// registered one-cycle pulse on each accepted 0->1 transition.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic sig_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, sync_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Timer only runs while the synchronized input disagrees with the accepted
    // level; any agreement (i.e. a bounce back) reloads it.
    always_comb begin
        cnt_d   = RELOAD;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == '0) begin
                level_d = sync_q;
                rise_d  = sync_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= RELOAD;
        end else begin
            meta_q  <= sig_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/dir_input_arbiter.sv
// Keyboard/switch direction arbiter with a single-entry pending-direction buffer.
// Define DIR_ARB_WASD_EN to also accept non-extended WASD makes.
//
// state   | meaning
// IDLE    | waiting for a prefix or a non-extended make
// EXT     | E0 seen; next byte is an extended make unless F0
// BRK     | F0 seen; next byte is a released key, discarded
// EXT_BRK | E0 F0 seen; next byte is a released extended key, discarded
module dir_input_arbiter
    import dir_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       upSig,
    input  logic       rightSig,
    input  logic       downSig,
    input  logic       leftSig,
    input  logic       load_req,
    output logic       dir_valid,
    output logic [2:0] dir_code,
    output logic       dir_src,
    output logic       overrun
);

    kb_state_e  state_q, state_d;
    logic       kb_req_q, kb_req_d;
    logic [2:0] kb_code_q, kb_code_d;

    logic [3:0] sw_raw;
    logic [3:0] sw_rise;
    logic [2:0] sw_code;

    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;
    logic       src_q, src_d;
    logic       ovr_q, ovr_d;

    always_comb begin
        state_d   = state_q;
        kb_code_d = DIR_NONE;
        if (ps2_key_pressed) begin
            case (state_q)
                IDLE: begin
                    if (ps2_key_data == SC_EXT) begin
                        state_d = EXT;
                    end else if (ps2_key_data == SC_BRK) begin
                        state_d = BRK;
                    end else begin
`ifdef DIR_ARB_WASD_EN
                        kb_code_d = wasd_dir(ps2_key_data);
`else
                        kb_code_d = DIR_NONE;
`endif
                    end
                end
                EXT: begin
                    if (ps2_key_data == SC_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        kb_code_d = arrow_dir(ps2_key_data);
                        state_d   = IDLE;
                    end
                end
                BRK:     state_d = IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        kb_req_d = (kb_code_d != DIR_NONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            kb_req_q  <= 1'b0;
            kb_code_q <= DIR_NONE;
        end else begin
            state_q   <= state_d;
            kb_req_q  <= kb_req_d;
            kb_code_q <= kb_code_d;
        end
    end

    assign sw_raw = {leftSig, downSig, rightSig, upSig};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        switch_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clock (clock),
            .resetn(resetn),
            .sig_i (sw_raw[g]),
            .rise_o(sw_rise[g])
        );
    end

    always_comb begin
        sw_code = DIR_NONE;
        if (sw_rise[0])      sw_code = DIR_UP;
        else if (sw_rise[1]) sw_code = DIR_RIGHT;
        else if (sw_rise[2]) sw_code = DIR_DOWN;
        else if (sw_rise[3]) sw_code = DIR_LEFT;
    end

    // A new request always wins over a pop in the same cycle; overrun only
    // when the old entry was never consumed.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        src_d   = src_q;
        ovr_d   = ovr_q;
        if (kb_req_q || (sw_code != DIR_NONE)) begin
            valid_d = 1'b1;
            code_d  = kb_req_q ? kb_code_q : sw_code;
            src_d   = !kb_req_q;
            if (valid_q && !load_req) ovr_d = 1'b1;
        end else if (load_req && valid_q) begin
            valid_d = 1'b0;
            code_d  = DIR_NONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            code_q  <= DIR_NONE;
            src_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            src_q   <= src_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dir_valid = valid_q;
    assign dir_code  = code_q;
    assign dir_src   = src_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_dir_input_arbiter.sv
// Directed bench for dir_input_arbiter: keyboard vector table plus switch,
// collision, pop and reset sequences.
module tb_dir_input_arbiter;

`ifdef DIR_ARB_WASD_EN
    localparam bit WASD = 1'b1;
`else
    localparam bit WASD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       upSig, rightSig, downSig, leftSig;
    logic       load_req;
    logic       dir_valid;
    logic [2:0] dir_code;
    logic       dir_src;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    dir_input_arbiter #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_key_data   (ps2_key_data),
        .upSig          (upSig),
        .rightSig       (rightSig),
        .downSig        (downSig),
        .leftSig        (leftSig),
        .load_req       (load_req),
        .dir_valid      (dir_valid),
        .dir_code       (dir_code),
        .dir_src        (dir_src),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       p;
        logic [7:0] d;
        logic       ld;
        logic       v;
        logic [2:0] c;
        logic       s;
        logic       o;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int v, input int c, input int s, input int o);
        check({tag, ".dir_valid"}, int'(dir_valid), v);
        check({tag, ".dir_code"},  int'(dir_code),  c);
        check({tag, ".dir_src"},   int'(dir_src),   s);
        check({tag, ".overrun"},   int'(overrun),   o);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        upSig = 1'b0; rightSig = 1'b0; downSig = 1'b0; leftSig = 1'b0;
        load_req = 1'b0;
        resetn   = 1'b0;
        steps(2);
        resetn = 1'b1;
        step();
    endtask

    task automatic key(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        step();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic add(input logic p, input logic [7:0] d, input logic ld,
                       input logic v, input logic [2:0] c, input logic s, input logic o);
        vec_t r;
        r.p = p; r.d = d; r.ld = ld; r.v = v; r.c = c; r.s = s; r.o = o;
        tbl.push_back(r);
    endtask

    initial begin
        int early;
        logic [2:0] wc;
        logic       wo;
        wc = WASD ? 3'd1 : 3'd4;
        wo = WASD;

        // p  data  ld   v  code s  ovr
        add(1, 8'hE0, 0, 0, 3'd0, 0, 0);
        add(1, 8'h75, 0, 0, 3'd0, 0, 0);
        add(0, 8'h00, 0, 1, 3'd1, 0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 0, 0);
        add(0, 8'h00, 1, 0, 3'd0, 0, 0);
        add(1, 8'hE0, 0, 0, 3'd0, 0, 0);
        add(1, 8'hF0, 0, 0, 3'd0, 0, 0);
        add(1, 8'h75, 0, 0, 3'd0, 0, 0);
        add(0, 8'h00, 0, 0, 3'd0, 0, 0);
        add(1, 8'hE0, 0, 0, 3'd0, 0, 0);
        add(1, 8'h6B, 0, 0, 3'd0, 0, 0);
        add(0, 8'h00, 0, 1, 3'd4, 0, 0);
        add(1, 8'h1D, 0, 1, 3'd4, 0, 0);
        add(0, 8'h00, 0, 1, wc,   0, wo);
        add(1, 8'hF0, 0, 1, wc,   0, wo);
        add(1, 8'h1D, 0, 1, wc,   0, wo);
        add(0, 8'h00, 0, 1, wc,   0, wo);
        add(1, 8'hE0, 0, 1, wc,   0, wo);
        add(1, 8'h74, 0, 1, wc,   0, wo);
        add(0, 8'h00, 0, 1, 3'd2, 0, 1);
        add(0, 8'h00, 1, 0, 3'd0, 0, 1);
        add(1, 8'hF0, 0, 0, 3'd0, 0, 1);
        add(1, 8'hE0, 0, 0, 3'd0, 0, 1);
        add(1, 8'h75, 0, 0, 3'd0, 0, 1);
        add(0, 8'h00, 0, 0, 3'd0, 0, 1);
        add(1, 8'hE0, 0, 0, 3'd0, 0, 1);
        add(1, 8'h12, 0, 0, 3'd0, 0, 1);
        add(0, 8'h00, 0, 0, 3'd0, 0, 1);

        do_reset();
        check_out("reset", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            ps2_key_pressed = tbl[i].p;
            ps2_key_data    = tbl[i].d;
            load_req        = tbl[i].ld;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].c, tbl[i].s, tbl[i].o);
        end
        ps2_key_pressed = 1'b0;
        load_req        = 1'b0;

        // Pop coinciding with a new request: new entry loads, no overrun.
        do_reset();
        key(8'hE0); key(8'h75); step();
        check_out("pop_new.first", 1, 1, 0, 0);
        key(8'hE0); key(8'h74);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check_out("pop_new.load", 1, 2, 0, 0);
        step();
        check_out("pop_new.hold", 1, 2, 0, 0);

        // Switch bounce then a clean hold: one request, exact latency.
        do_reset();
        early = 0;
        for (int r = 0; r < 4; r++) begin
            rightSig = 1'b1;
            for (int k = 0; k < 3; k++) begin step(); if (dir_valid) early++; end
            rightSig = 1'b0;
            for (int k = 0; k < 3; k++) begin step(); if (dir_valid) early++; end
        end
        check("sw.glitch_no_req", early, 0);
        rightSig = 1'b1;
        early = 0;
        for (int k = 0; k < 18; k++) begin step(); if (dir_valid) early++; end
        check("sw.before_latency", early, 0);
        step();
        check_out("sw.at_latency", 1, 2, 1, 0);
        steps(5);
        check_out("sw.held", 1, 2, 1, 0);
        load_req = 1'b1; step(); load_req = 1'b0;
        check_out("sw.pop", 0, 0, 1, 0);
        steps(25);
        check("sw.no_repeat", int'(dir_valid), 0);
        rightSig = 1'b0;
        steps(25);
        check_out("sw.fall_ignored", 0, 0, 1, 0);

        // Keyboard and switch edge in the same cycle: keyboard wins.
        do_reset();
        upSig = 1'b1;
        steps(16);
        key(8'hE0);
        key(8'h72);
        step();
        check_out("collide", 1, 3, 0, 0);
        steps(25);
        check_out("collide.after", 1, 3, 0, 0);

        // Two switches rising together: higher priority wins, loser dropped.
        load_req = 1'b1; step(); load_req = 1'b0;
        rightSig = 1'b1; leftSig = 1'b1;
        steps(19);
        check_out("prio", 1, 2, 1, 0);
        steps(25);
        check_out("prio.after", 1, 2, 1, 0);

        // Reset in the middle of an extended sequence discards the prefix.
        do_reset();
        key(8'hE0);
        resetn = 1'b0;
        step();
        check_out("rst_mid.during", 0, 0, 0, 0);
        resetn = 1'b1;
        step();
        key(8'h75);
        steps(2);
        check_out("rst_mid.after", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dir_input_arbiter.md
# dir_input_arbiter

Direction-command arbiter between the PS/2 keyboard path and the four board direction switches, feeding the processor's keyboard-load port. Decodes scancode set 2 make/break sequences, debounces the switch inputs, arbitrates the two sources, and holds one pending direction in a single-entry buffer. The processor consumes the buffer with a load strobe.

## Interface
- DEBOUNCE_CYCLES, 16: clock cycles a synchronized switch level must hold stable before it is accepted; minimum 2.
- CNT_W, 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; the only clock domain.
- resetn  in  1  asynchronous, active-low reset.
- ps2_key_pressed  in  1  one-cycle strobe; a new byte is present on ps2_key_data.
- ps2_key_data  in  8  PS/2 scancode byte.
- upSig, rightSig, downSig, leftSig  in  1 each  raw switch levels; asynchronous to clock.
- load_req  in  1  processor load strobe; pops the pending direction.
- dir_valid  out  1  the pending direction is available.
- dir_code  out  3  direction: 0 none, 1 up, 2 right, 3 down, 4 left.
- dir_src  out  1  source of the pending direction: 0 keyboard, 1 switch.
- overrun  out  1  sticky flag; an unconsumed direction was overwritten.

## Operation
- All outputs reset to 0. Reset clears FSM state, debounce counters and synchronizers; an in-progress scancode sequence is discarded.
- Scancode FSM (advances only on ps2_key_pressed):
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte stays in IDLE and is treated as a non-extended make.
  - EXT: F0 goes to EXT_BRK; any other byte is an extended make, then return to IDLE.
  - BRK: the next byte is consumed and ignored, then return to IDLE.
  - EXT_BRK: the next byte is consumed and ignored, then return to IDLE.
- Extended makes that produce requests: 75 up, 74 right, 72 down, 6B left. Every other make byte is ignored.
- Break codes never generate or cancel a request.
- Switch path: each switch goes through a 2-flop synchronizer, then a debouncer. A 0→1 transition of the debounced level raises a one-cycle request for that direction. 1→0 transitions are ignored.
- Several switch requests in one cycle are resolved by priority up > right > down > left. The losing requests are dropped.
- Arbitration: a keyboard request beats a switch request in the same cycle. The losing switch request is dropped and does not set overrun.
- Buffer: the winning request writes dir_code and dir_src and sets dir_valid. This happens even when dir_valid is already 1 (latest wins).
- overrun is set when a request arrives while dir_valid=1 and load_req=0. It clears only on reset.
- Pop: load_req with dir_valid=1 clears dir_valid and sets dir_code to 0 on the next edge. If a new request arrives in the same cycle, the new request loads and dir_valid stays 1, with no overrun.
- load_req with dir_valid=0 has no effect.

## Timing
- Keyboard latency: a qualifying byte strobed at edge N gives dir_valid=1 after edge N+1.
- Switch latency: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 buffer cycle after the switch level first becomes stable.
- Switch bounce: any change within the debounce window restarts that switch's counter.
- Outputs are registered. There are no combinational paths from any input to any output.
- Pop: dir_valid falls exactly one edge after the cycle in which load_req is sampled high.

## Configuration
- DIR_ARB_WASD_EN defined: non-extended makes also generate requests: 1D up, 23 right, 1B down, 1C left. Extended arrow makes still work.
- DIR_ARB_WASD_EN undefined: non-extended makes are ignored. Only arrow keys and switches generate requests.

## Structure
- Shared package dir_arb_pkg holds:
  - direction code constants DIR_NONE, DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT;
  - scancode constants for E0, F0, the four arrows and WASD;
  - the FSM state encoding IDLE, EXT, BRK, EXT_BRK.
- Sub-module switch_debouncer (synchronizer + counter + rising-edge pulse), instantiated four times.

## Test plan
- Extended make: strobe E0, then 75 → dir_valid=1, dir_code=1, dir_src=0 one cycle after the 75 strobe. Then load_req → dir_valid=0, dir_code=0.
- Extended break: strobe E0, F0, 75 → no request; FSM back in IDLE. A following E0, 6B → dir_code=4.
- Switch debounce: toggle rightSig with 3-cycle glitches, then hold it high for 20 cycles → exactly one request, dir_code=2, dir_src=1, at cycle 2+16+1 after it settles.
- Same-cycle collision: keyboard 72 (after E0) and a debounced upSig edge land in one cycle → dir_code=3, dir_src=0, overrun=0.
- Overwrite and pop: an unconsumed up request followed by an E0 74 → dir_code=2, overrun=1. A load_req coinciding with a new request → dir_valid stays 1 and overrun does not re-set.
- Reset mid-sequence: strobe E0, assert resetn=0, release it, strobe 75 → no request (with DIR_ARB_WASD_EN undefined); all outputs 0.
